// File: rtl/pipe_pkg.sv
// Shared IF/ID packet layout and constants used by the fetch/decode buffer.
package pipe_pkg;

    typedef struct packed {
        logic [15:0] pc_curr;
        logic [15:0] pc_next;
        logic [15:0] inst;
        logic [1:0]  prediction;
        logic [15:0] pred_target;
    } if_id_pkt_t;

    localparam int IF_ID_PKT_W = $bits(if_id_pkt_t);

    localparam logic [15:0] NOP_INST = 16'h0000;

    // Packet presented to decode when nothing is held: a NOP with no prediction.
    function automatic if_id_pkt_t bubble_pkt();
        if_id_pkt_t p;
        p             = '0;
        p.inst        = NOP_INST;
        p.prediction  = 2'b00;
        return p;
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// Register array backing the IF/ID buffer: one synchronous write port, one asynchronous read port.
module pipe_buf_mem #(
    parameter int DATA_W = 66,
    parameter int DEPTH  = 2,
    parameter int AW     = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_pipe_buf.sv
// Elastic IF/ID pipeline buffer: DEPTH-entry circular queue with valid/ready on both sides.
// Optional occupancy statistics are enabled by defining IF_ID_STATS_EN.
module if_id_pipe_buf
    import pipe_pkg::*;
#(
    parameter  int DATA_W = IF_ID_PKT_W,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
`ifdef IF_ID_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] BUBBLE   = DATA_W'(bubble_pkt());

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  occ;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] rd_data;

    // Acceptance looks only at registered occupancy so decode stalls never reach fetch combinationally.
    assign in_ready  = (occ < FULL_CNT) & ~rst & ~flush;
    assign out_valid = (occ != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? rd_data : BUBBLE;
    assign count     = occ;

    pipe_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr),
        .wdata  (in_data),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

    // Flush wins over any handshake in the same cycle and rewinds both pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef IF_ID_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (flush && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Scoreboard bench for if_id_pipe_buf: directed scenarios plus random traffic against a queue model.
module tb_if_id_pipe_buf;
    import pipe_pkg::*;

    localparam int DEPTH  = 2;
    localparam int DATA_W = IF_ID_PKT_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
`ifdef IF_ID_STATS_EN
    logic [15:0]       stall_cycles;
    logic [15:0]       flush_count;
    logic [15:0]       stall_m;
    logic [15:0]       flush_m;
`endif

    int errors = 0;
    int checks = 0;

    // Packets the reference model currently believes are held, oldest first.
    logic [DATA_W-1:0] exp_q[$];

    if_id_pipe_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count)
`ifdef IF_ID_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    function automatic logic [DATA_W-1:0] mk_pkt(input logic [15:0] pc, input logic [15:0] inst);
        if_id_pkt_t p;
        p.pc_curr     = pc;
        p.pc_next     = pc + 16'd2;
        p.inst        = inst;
        p.prediction  = 2'($urandom_range(0, 3));
        p.pred_target = 16'($urandom);
        return DATA_W'(p);
    endfunction

    // Monitor: inputs are stable from posedge+1 until the next posedge, so the negedge
    // both checks the present outputs and advances the model across the coming edge.
    always @(negedge clk) begin
        logic exp_ready;
        if (rst) begin
            exp_q.delete();
        end
        exp_ready = !rst && !flush && (exp_q.size() < DEPTH);
        checkOutput("count", 128'(count), 128'(exp_q.size()));
        checkOutput("in_ready", 128'(in_ready), 128'(exp_ready));
        checkOutput("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            checkOutput("out_data", 128'(out_data), 128'(exp_q[0]));
        end else begin
            checkOutput("bubble_data", 128'(out_data), 128'(0));
        end
`ifdef IF_ID_STATS_EN
        if (rst) begin
            stall_m = '0;
            flush_m = '0;
        end
        checkOutput("stall_cycles", 128'(stall_cycles), 128'(stall_m));
        checkOutput("flush_count", 128'(flush_count), 128'(flush_m));
        if (!rst) begin
            if (exp_q.size() != 0 && !out_ready && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
            if (flush && flush_m != 16'hFFFF) flush_m = flush_m + 16'd1;
        end
`endif
        if (!rst) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                if (exp_ready && in_valid) exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef IF_ID_STATS_EN
        stall_m   = '0;
        flush_m   = '0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single packet through an idle buffer.
        applyStimulus(1'b1, mk_pkt(16'h0010, 16'hA123), 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Three offers into a stalled buffer, then release decode.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, mk_pkt(16'h0100 + 16'(2 * i), 16'hB000 + 16'(i)), 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Flush a full buffer while fetch offers another packet.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, mk_pkt(16'h0200 + 16'(2 * i), 16'hC000 + 16'(i)), 1'b0, 1'b0);
        applyStimulus(1'b1, mk_pkt(16'h0300, 16'hDEAD), 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Sustained streaming exercises pointer wrap.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, mk_pkt(16'h0400 + 16'(2 * i), 16'(i * 16'h1111)), 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges while two packets are held.
        applyStimulus(1'b1, mk_pkt(16'h0500, 16'hE001), 1'b0, 1'b0);
        applyStimulus(1'b1, mk_pkt(16'h0502, 16'hE002), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("held_before_rst", 128'(count), 128'(2));
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_count", 128'(count), 128'(0));
        checkOutput("async_rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("async_rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0);

`ifdef IF_ID_STATS_EN
        // Stall a valid head for several cycles, flush twice, then pin the counters at all-ones.
        applyStimulus(1'b1, mk_pkt(16'h0600, 16'hF00D), 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b1, mk_pkt(16'h0700, 16'hF00E), 1'b0, 1'b0);
        #1;
        force dut.stall_q = 16'hFFFF;
        force dut.flush_q = 16'hFFFF;
        stall_m = 16'hFFFF;
        flush_m = 16'hFFFF;
        #1;
        release dut.stall_q;
        release dut.flush_q;
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0);
`endif

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          mk_pkt(16'($urandom), 16'($urandom)),
                          $urandom_range(0, 2) != 0,
                          $urandom_range(0, 31) == 0);
        end
        repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
